// File: rtl/cmd_pkg.sv
// Shared constants, state encodings and helpers for the UART command controller.
package cmd_pkg;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_L  = 8'h4C;
    localparam logic [7:0] ASC_C  = 8'h43;
    localparam logic [7:0] ASC_R  = 8'h52;
    localparam logic [7:0] ASC_LL = 8'h6C;
    localparam logic [7:0] ASC_LC = 8'h63;
    localparam logic [7:0] ASC_LR = 8'h72;

    localparam int REPLY_LEN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_TERM,
        ST_DISCARD,
        ST_REPLY
    } rx_state_t;

    typedef enum logic [1:0] {
        CMD_L,
        CMD_C,
        CMD_R
    } cmd_t;

    function automatic logic is_cmd(input logic [7:0] b, input logic [7:0] up,
                                    input logic [7:0] lo, input logic ci);
        return (b == up) || (ci && (b == lo));
    endfunction

endpackage

// File: rtl/hex_nibble.sv
// Combinational ASCII hex digit decoder plus nibble-to-uppercase-ASCII encoder.
// Zero latency, no flow control.
module hex_nibble #(
    parameter bit CASE_INS = 1'b1
) (
    input  logic [7:0] char_in,
    input  logic [3:0] nib_in,
    output logic [3:0] nib,
    output logic       is_hex,
    output logic [7:0] ascii
);

    always_comb begin
        nib    = 4'h0;
        is_hex = 1'b0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            nib    = char_in[3:0];
            is_hex = 1'b1;
        end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                     (CASE_INS && char_in >= 8'h61 && char_in <= 8'h66)) begin
            // 'A'/'a' carry 1 in the low nibble, so +9 lands on 10
            nib    = char_in[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

    assign ascii = (nib_in < 4'd10) ? (8'h30 + {4'h0, nib_in}) : (8'h37 + {4'h0, nib_in});

endmodule

// File: rtl/cmd_rx_ctl.sv
// Parses "Lhh", "C", "R" command lines into an LED register and streams a hex reply for R.
// Pulses land one cycle after the CR; reply bytes wait on tx_rdy with a one-cycle gap after each strobe.
module cmd_rx_ctl
    import cmd_pkg::*;
#(
    parameter logic [7:0] LED_RST  = 8'h00,
    parameter bit         CASE_INS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       d_rdy,
    input  logic       tx_rdy,
    output logic [7:0] dout,
    output logic       tx_en,
    output logic [7:0] leds,
    output logic       cmd_ok,
    output logic       cmd_err
);

    localparam logic [1:0] LAST_IDX = 2'(REPLY_LEN - 1);

    rx_state_t  state, state_nxt;
    cmd_t       cmd, cmd_nxt;
    logic [3:0] hi_nib, hi_nxt, lo_nib, lo_nxt;
    logic [1:0] idx, idx_nxt;
    logic       hold;

    logic [7:0] leds_nxt, tx_byte;
    logic       ok_nxt, err_nxt, issue;

    logic [3:0] din_nib, enc_nib;
    logic       din_hex;
    logic [7:0] enc_char;
    logic       is_cr;

    assign enc_nib = idx[0] ? leds[3:0] : leds[7:4];
    assign is_cr   = (din == ASC_CR);

    hex_nibble #(.CASE_INS(CASE_INS)) u_hex (
        .char_in (din),
        .nib_in  (enc_nib),
        .nib     (din_nib),
        .is_hex  (din_hex),
        .ascii   (enc_char)
    );

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        hi_nxt    = hi_nib;
        lo_nxt    = lo_nib;
        idx_nxt   = idx;
        leds_nxt  = leds;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        issue     = 1'b0;
        tx_byte   = enc_char;

        if (state == ST_REPLY) begin
            // leds cannot change while replying, so it is the CR-time snapshot
            if (tx_rdy && !tx_en && !hold) begin
                issue = 1'b1;
                if (idx == 2'd2)
                    tx_byte = ASC_CR;
                else if (idx == LAST_IDX)
                    tx_byte = ASC_LF;
                if (idx == LAST_IDX) begin
                    idx_nxt   = 2'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    idx_nxt = idx + 2'd1;
                end
            end
        end else if (d_rdy && din != ASC_LF) begin
            case (state)
                ST_IDLE: begin
                    if (is_cmd(din, ASC_L, ASC_LL, CASE_INS)) begin
                        cmd_nxt   = CMD_L;
                        state_nxt = ST_HI;
                    end else if (is_cmd(din, ASC_C, ASC_LC, CASE_INS)) begin
                        cmd_nxt   = CMD_C;
                        state_nxt = ST_TERM;
                    end else if (is_cmd(din, ASC_R, ASC_LR, CASE_INS)) begin
                        cmd_nxt   = CMD_R;
                        state_nxt = ST_TERM;
                    end else if (!is_cr) begin
                        state_nxt = ST_DISCARD;
                    end
                end
                ST_HI, ST_LO: begin
                    if (din_hex) begin
                        if (state == ST_HI) begin
                            hi_nxt    = din_nib;
                            state_nxt = ST_LO;
                        end else begin
                            lo_nxt    = din_nib;
                            state_nxt = ST_TERM;
                        end
                    end else if (is_cr) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DISCARD;
                    end
                end
                ST_TERM: begin
                    if (is_cr) begin
                        ok_nxt    = 1'b1;
                        state_nxt = ST_IDLE;
                        case (cmd)
                            CMD_L:   leds_nxt = {hi_nib, lo_nib};
                            CMD_C:   leds_nxt = LED_RST;
                            default: state_nxt = ST_REPLY;
                        endcase
                    end else begin
                        state_nxt = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (is_cr) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cmd    <= CMD_L;
            hi_nib <= 4'h0;
            lo_nib <= 4'h0;
            idx    <= 2'd0;
            hold   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cmd    <= cmd_nxt;
            hi_nib <= hi_nxt;
            lo_nib <= lo_nxt;
            idx    <= idx_nxt;
            hold   <= tx_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds    <= LED_RST;
            dout    <= 8'h00;
            tx_en   <= 1'b0;
            cmd_ok  <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            leds    <= leds_nxt;
            tx_en   <= issue;
            cmd_ok  <= ok_nxt;
            cmd_err <= err_nxt;
            if (issue)
                dout <= tx_byte;
        end
    end

endmodule

// File: tb/tb_cmd_rx_ctl.sv
// Bench for cmd_rx_ctl: two instances (case-insensitive/LED_RST=00 and case-sensitive/LED_RST=5A)
// fed the same byte stream; table vectors, directed reply/reset sequences, then random lines.
module tb_cmd_rx_ctl;

    localparam logic [7:0] RST0 = 8'h00;
    localparam logic [7:0] RST1 = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       d_rdy, tx_rdy;
    logic [7:0] dout0, dout1, leds0, leds1;
    logic       tx_en0, tx_en1, ok0, ok1, err0, err1;

    cmd_rx_ctl #(.LED_RST(RST0), .CASE_INS(1'b1)) dut0 (
        .clk(clk), .rst(rst), .din(din), .d_rdy(d_rdy), .tx_rdy(tx_rdy),
        .dout(dout0), .tx_en(tx_en0), .leds(leds0), .cmd_ok(ok0), .cmd_err(err0)
    );

    cmd_rx_ctl #(.LED_RST(RST1), .CASE_INS(1'b0)) dut1 (
        .clk(clk), .rst(rst), .din(din), .d_rdy(d_rdy), .tx_rdy(tx_rdy),
        .dout(dout1), .tx_en(tx_en1), .leds(leds1), .cmd_ok(ok1), .cmd_err(err1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic rdy_q;
    always @(posedge clk) rdy_q <= tx_rdy;

    byte unsigned exp_tx0[$], exp_tx1[$];
    int ntx0 = 0, ntx1 = 0;
    int nok0 = 0, nerr0 = 0, nok1 = 0, nerr1 = 0;

    always @(negedge clk) begin
        if (ok0)  nok0++;
        if (err0) nerr0++;
        if (ok1)  nok1++;
        if (err1) nerr1++;
        if (tx_en0) begin
            ntx0++;
            check("tx0_after_rdy", rdy_q, 1);
            if (exp_tx0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx0_extra: byte %0h sent, none expected", dout0);
            end else check("tx0_dout", dout0, exp_tx0.pop_front());
        end
        if (tx_en1) begin
            ntx1++;
            check("tx1_after_rdy", rdy_q, 1);
            if (exp_tx1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx1_extra: byte %0h sent, none expected", dout1);
            end else check("tx1_dout", dout1, exp_tx1.pop_front());
        end
    end

    // tx_rdy driver: 0 random, 1 drop for 50 cycles after each strobe, 2 always ready
    int tx_mode = 2;
    int hold_cnt = 0;
    always @(negedge clk) begin
        if (tx_mode == 0)
            tx_rdy = ($urandom_range(0, 3) != 0);
        else if (tx_mode == 1) begin
            if (tx_en0) hold_cnt = 50;
            if (hold_cnt > 0) begin
                tx_rdy = 1'b0;
                hold_cnt--;
            end else tx_rdy = 1'b1;
        end else tx_rdy = 1'b1;
    end

    // ---------------- reference model ----------------
    byte unsigned line_q[$];
    logic [7:0]   lval;
    logic [7:0]   m_leds0 = RST0, m_leds1 = RST1;
    int eok0 = 0, eerr0 = 0, eok1 = 0, eerr1 = 0;

    function automatic bit hex_ok(input byte unsigned c, input bit ci);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (ci && c >= "a" && c <= "f");
    endfunction

    function automatic logic [3:0] hex_val(input byte unsigned c);
        int v;
        if (c <= "9")      v = c - "0";
        else if (c <= "F") v = c - "A" + 10;
        else               v = c - "a" + 10;
        return v[3:0];
    endfunction

    function automatic byte unsigned hex_chr(input logic [3:0] n);
        int v;
        v = (n < 10) ? ("0" + n) : ("A" + n - 10);
        return v[7:0];
    endfunction

    // 0 empty line, 1 rejected, 2 L ok (value in lval), 3 C ok, 4 R ok
    function automatic int classify(input bit ci);
        byte unsigned f[$];
        byte unsigned c;
        foreach (line_q[i]) if (line_q[i] != 8'h0A) f.push_back(line_q[i]);
        if (f.size() == 0) return 0;
        c = f[0];
        if (ci && c >= "a" && c <= "z") c = c - 8'h20;
        if (f.size() == 1 && c == "C") return 3;
        if (f.size() == 1 && c == "R") return 4;
        if (f.size() == 3 && c == "L" && hex_ok(f[1], ci) && hex_ok(f[2], ci)) begin
            lval = {hex_val(f[1]), hex_val(f[2])};
            return 2;
        end
        return 1;
    endfunction

    // ---------------- stimulus ----------------
    logic s_ok0, s_ok1, s_err0, s_err1;

    task automatic send_byte(input byte unsigned b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        din   = b;
        d_rdy = 1'b1;
        @(negedge clk);
        d_rdy  = 1'b0;
        din    = 8'h00;
        s_ok0  = ok0;  s_err0 = err0;
        s_ok1  = ok1;  s_err1 = err1;
    endtask

    task automatic send_line(input int maxgap);
        foreach (line_q[i]) send_byte(line_q[i], $urandom_range(0, maxgap));
        send_byte(8'h0D, $urandom_range(0, maxgap));
    endtask

    task automatic queue_reply(input int dut, input logic [7:0] v);
        if (dut == 0) begin
            exp_tx0.push_back(hex_chr(v[7:4])); exp_tx0.push_back(hex_chr(v[3:0]));
            exp_tx0.push_back(8'h0D);           exp_tx0.push_back(8'h0A);
        end else begin
            exp_tx1.push_back(hex_chr(v[7:4])); exp_tx1.push_back(hex_chr(v[3:0]));
            exp_tx1.push_back(8'h0D);           exp_tx1.push_back(8'h0A);
        end
    endtask

    task automatic do_line(input int maxgap);
        int c0, c1;
        logic [7:0] v0, v1;
        c0 = classify(1'b1); v0 = lval;
        c1 = classify(1'b0); v1 = lval;
        if (c0 == 2) m_leds0 = v0;
        if (c0 == 3) m_leds0 = RST0;
        if (c1 == 2) m_leds1 = v1;
        if (c1 == 3) m_leds1 = RST1;
        if (c0 == 4) queue_reply(0, m_leds0);
        if (c1 == 4) queue_reply(1, m_leds1);
        eok0 += (c0 >= 2) ? 1 : 0;  eerr0 += (c0 == 1) ? 1 : 0;
        eok1 += (c1 >= 2) ? 1 : 0;  eerr1 += (c1 == 1) ? 1 : 0;
        send_line(maxgap);
        check("line_ok0",  s_ok0,  (c0 >= 2));
        check("line_err0", s_err0, (c0 == 1));
        check("line_leds0", leds0, m_leds0);
        check("line_ok1",  s_ok1,  (c1 >= 2));
        check("line_err1", s_err1, (c1 == 1));
        check("line_leds1", leds1, m_leds1);
    endtask

    task automatic wait_replies(input int budget);
        for (int k = 0; k < budget && (exp_tx0.size() != 0 || exp_tx1.size() != 0); k++)
            @(negedge clk);
        check("reply_drained0", exp_tx0.size(), 0);
        check("reply_drained1", exp_tx1.size(), 0);
    endtask

    task automatic wait_tx0(input int target, input int budget);
        for (int k = 0; k < budget && ntx0 < target; k++) @(negedge clk);
    endtask

    string hexs = "0123456789ABCDEFabcdef";

    task automatic gen_line();
        int t, n;
        line_q.delete();
        t = $urandom_range(0, 7);
        case (t)
            0, 4, 5: begin
                line_q.push_back($urandom_range(0, 1) ? 8'h4C : 8'h6C);
                n = (t == 0) ? 2 : (t == 4) ? 1 : 3;
                for (int i = 0; i < n; i++) line_q.push_back(hexs[$urandom_range(0, 21)]);
            end
            1: line_q.push_back($urandom_range(0, 1) ? 8'h43 : 8'h63);
            2: line_q.push_back($urandom_range(0, 1) ? 8'h52 : 8'h72);
            3: ;
            6: begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) line_q.push_back(8'($urandom_range(8'h20, 8'h7E)));
            end
            default: begin
                line_q.push_back(8'h4C);
                line_q.push_back(hexs[$urandom_range(0, 21)]);
                line_q.push_back(8'($urandom_range(8'h47, 8'h5A)));
            end
        endcase
        if ($urandom_range(0, 7) == 0)
            line_q.insert($urandom_range(0, line_q.size()), 8'h0A);
    endtask

    typedef struct {
        logic [47:0] txt;
        int          len;
        bit          ok0, err0;
        logic [7:0]  led0;
        bit          ok1, err1;
        logic [7:0]  led1;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int base0, base1;
        logic [47:0] t;

        tbl[0] = '{"L3F",   3, 1, 0, 8'h3F, 1, 0, 8'h3F};
        tbl[1] = '{"l3f\n", 4, 1, 0, 8'h3F, 0, 1, 8'h3F};
        tbl[2] = '{"LG1",   3, 0, 1, 8'h3F, 0, 1, 8'h3F};
        tbl[3] = '{"L3",    2, 0, 1, 8'h3F, 0, 1, 8'h3F};
        tbl[4] = '{"C",     1, 1, 0, 8'h00, 1, 0, 8'h5A};
        tbl[5] = '{"",      0, 0, 0, 8'h00, 0, 0, 8'h5A};
        tbl[6] = '{"LFFF",  4, 0, 1, 8'h00, 0, 1, 8'h5A};
        tbl[7] = '{"La5",   3, 1, 0, 8'hA5, 0, 1, 8'h5A};
        tbl[8] = '{"L5z",   3, 0, 1, 8'hA5, 0, 1, 8'h5A};

        rst = 1'b1; din = 8'h00; d_rdy = 1'b0; tx_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_leds0", leds0, RST0);
        check("rst_leds1", leds1, RST1);
        check("rst_tx_en", tx_en0, 0);
        check("rst_dout",  dout0, 0);
        check("rst_ok",    ok0, 0);
        check("rst_err",   err0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // table vectors
        for (int i = 0; i < 9; i++) begin
            t = tbl[i].txt;
            line_q.delete();
            for (int j = 0; j < tbl[i].len; j++) line_q.push_back(t[8*(tbl[i].len-1-j) +: 8]);
            send_line(1);
            check("tbl_ok0",   s_ok0,  tbl[i].ok0);
            check("tbl_err0",  s_err0, tbl[i].err0);
            check("tbl_leds0", leds0,  tbl[i].led0);
            check("tbl_ok1",   s_ok1,  tbl[i].ok1);
            check("tbl_err1",  s_err1, tbl[i].err1);
            check("tbl_leds1", leds1,  tbl[i].led1);
            eok0 += tbl[i].ok0; eerr0 += tbl[i].err0;
            eok1 += tbl[i].ok1; eerr1 += tbl[i].err1;
        end
        m_leds0 = 8'hA5;
        m_leds1 = RST1;

        // R with tx_rdy dropping for 50 cycles after every strobe; bytes mid-reply are dropped
        tx_mode = 1;
        base0 = ntx0; base1 = ntx1;
        line_q.delete(); line_q.push_back(8'h52);
        do_line(0);
        wait_tx0(base0 + 2, 500);
        check("reply_first_two", ntx0 - base0, 2);
        line_q.delete();
        line_q.push_back(8'h4C); line_q.push_back(8'h30); line_q.push_back(8'h30);
        send_line(0);
        check("inject_no_ok",  s_ok0,  0);
        check("inject_no_err", s_err0, 0);
        wait_replies(1000);
        repeat (120) @(negedge clk);
        check("reply_count0", ntx0 - base0, 4);
        check("reply_count1", ntx1 - base1, 4);
        check("reply_leds0", leds0, 8'hA5);

        // reset in the middle of a reply
        base0 = ntx0;
        line_q.delete(); line_q.push_back(8'h52);
        do_line(0);
        wait_tx0(base0 + 2, 500);
        check("pre_rst_two", ntx0 - base0, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_en", tx_en0, 0);
        check("mid_rst_leds0", leds0, RST0);
        check("mid_rst_leds1", leds1, RST1);
        exp_tx0.delete(); exp_tx1.delete();
        m_leds0 = RST0; m_leds1 = RST1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tx_mode = 2;
        repeat (60) @(negedge clk);
        check("no_tx_after_rst", ntx0 - base0, 2);
        line_q.delete();
        line_q.push_back(8'h4C); line_q.push_back(8'h30); line_q.push_back(8'h31);
        do_line(1);
        check("post_rst_leds", leds0, 8'h01);

        // random lines against the line-level model
        tx_mode = 0;
        for (int n = 0; n < 150; n++) begin
            gen_line();
            do_line(2);
            wait_replies(2000);
        end
        repeat (20) @(negedge clk);

        check("total_ok0",  nok0,  eok0);
        check("total_err0", nerr0, eerr0);
        check("total_ok1",  nok1,  eok1);
        check("total_err1", nerr1, eerr1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_rx_ctl.md
# cmd_rx_ctl

Receive-side command controller for the UART design. It sits between the UART receiver (`din`/`d_rdy`) and the UART transmitter (`dout`/`tx_en`/`tx_rdy`). It parses ASCII command lines typed by the host and drives an 8-bit LED register. It answers a read command by streaming a short hex reply back to the transmitter.

## Interface
Parameters:
- `LED_RST`, 8'h00, value loaded into `leds` on reset and by the `C` command.
- `CASE_INS`, 1, when 1 the command letters and hex digits a–f are accepted in lower case too.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  8  received byte from the UART receiver; valid when `d_rdy`=1.
- `d_rdy`  in  1  one-cycle strobe per received byte.
- `tx_rdy`  in  1  transmitter idle and able to accept a byte.
- `dout`  out  8  byte to the transmitter; valid when `tx_en`=1.
- `tx_en`  out  1  one-cycle strobe requesting transmission of `dout`.
- `leds`  out  8  LED register.
- `cmd_ok`  out  1  one-cycle pulse: a command line executed.
- `cmd_err`  out  1  one-cycle pulse: a line was rejected.

## Operation
- Command grammar (CR = 8'h0D terminates; LF = 8'h0A is ignored in every receive state):
  - `L h h CR`: set `leds` to hex value hh, high nibble first.
  - `C CR`: set `leds` to `LED_RST`.
  - `R CR`: reply with two uppercase hex digits of `leds`, then CR, then LF.
- Receive FSM states:
  - IDLE: on `L` go to HI; on `C`/`R` go to TERM (remember which command); on CR stay in IDLE with no pulse (empty line); any other byte goes to DISCARD.
  - HI: a hex digit latches the high nibble and goes to LO; otherwise go to DISCARD.
  - LO: a hex digit latches the low nibble and goes to TERM; otherwise go to DISCARD.
  - TERM: CR executes the command, pulses `cmd_ok`, and returns to IDLE (or goes to REPLY for `R`); any other byte goes to DISCARD.
  - DISCARD: swallow bytes until CR, then pulse `cmd_err` and go to IDLE. A non-hex byte or an early CR both count as errors; an early CR pulses `cmd_err` immediately and returns to IDLE.
  - REPLY: send 4 bytes via the TX handshake (index counter 0..3), then go to IDLE.
- While in REPLY, `d_rdy` strobes are dropped silently: no state change, no pulse.
- `leds` changes only on a successful `L` or `C` execution. Errors never modify `leds`.
- Hex decode: '0'–'9' map to 0–9, 'A'–'F' map to 10–15, and 'a'–'f' map to 10–15 when `CASE_INS`=1. Hex encode always produces uppercase.

## Timing
- Reset values: `leds`=`LED_RST`, `dout`=0, `tx_en`=0, `cmd_ok`=0, `cmd_err`=0, FSM=IDLE, reply index=0.
- Each `d_rdy` strobe is consumed at the posedge where it is high. `cmd_ok`/`cmd_err` are registered and high for exactly the one cycle after the edge that sampled the terminating CR. `leds` takes its new value at that same edge.
- TX handshake:
  - `tx_en` is asserted only in a cycle following an edge where `tx_rdy`=1.
  - After each `tx_en`, the block holds off one cycle, then waits for `tx_rdy`=1 before issuing the next byte.
  - `dout` holds its value until the next `tx_en`.
- `R` latency: the first `tx_en` comes no earlier than 1 cycle after the `cmd_ok` cycle. The reply value is the `leds` snapshot taken at the CR.
- `rst` mid-line or mid-reply: outputs go immediately to their reset values. A partially sent reply is abandoned.

## Structure
- Shared package `cmd_pkg`:
  - ASCII constants: CR, LF, 'L', 'C', 'R', 'l', 'c', 'r'.
  - Receive FSM state encoding.
  - Reply length constant 4.
- Sub-module `hex_nibble`: combinational ASCII↔nibble converter with outputs `nib`, `is_hex` and `ascii`. It is instantiated once for decode and used for encode.
- FSM and TX sequencer live in one always block; output registers live in a separate block.

## Test plan
- "L3F\r" with `LED_RST`=0 -> `leds`=8'h3F; one `cmd_ok` pulse 1 cycle after the CR strobe; `cmd_err` stays 0.
- "l3f\n\r" with `CASE_INS`=1 -> `leds`=8'h3F and `cmd_ok`. With `CASE_INS`=0 -> `cmd_err` and `leds` unchanged.
- "LG1\r" and "L3\r" -> one `cmd_err` each; `leds` unchanged; the next "C\r" yields `leds`=`LED_RST` and `cmd_ok`.
- `leds`=8'hA5, then "R\r" with `tx_rdy` dropping for 50 cycles after each `tx_en` -> `dout` sequence 8'h41, 8'h35, 8'h0D, 8'h0A; exactly 4 `tx_en` pulses, each only while `tx_rdy`=1. Bytes injected during the reply are ignored.
- Assert `rst` after the 2nd reply byte -> `tx_en`=0 and `leds`=`LED_RST` immediately; after release, "L01\r" gives `leds`=8'h01.
- "\r" alone -> no pulse. "LFFF\r" -> `cmd_err`, `leds` unchanged.
